// File: rtl/pipe_stage_chain.sv
// Generic N-stage pipeline register chain with per-stage stall/flush and forwarding lookup.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_chain #(
   parameter  int unsigned DATA_W     = 32,
   parameter  int unsigned NB_ADDR    = 5,
   parameter  int unsigned NUM_STAGES = 4,
   localparam int unsigned NB_SEL     = $clog2(NUM_STAGES + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_dunit_clk_en,
   input  logic                  i_in_valid,
   input  logic [DATA_W-1:0]     i_in_data,
   input  logic [NB_ADDR-1:0]    i_in_rd,
   input  logic                  i_in_regwrite,
   output logic                  o_in_ready,
   input  logic [NUM_STAGES-1:0] i_stall,
   input  logic [NUM_STAGES-1:0] i_flush,
   input  logic [NB_ADDR-1:0]    i_rs_addr,
   input  logic [NB_ADDR-1:0]    i_rt_addr,
   output logic [NB_SEL-1:0]     o_fwd_a,
   output logic [NB_SEL-1:0]     o_fwd_b,
   output logic [DATA_W-1:0]     o_fwd_data_a,
   output logic [DATA_W-1:0]     o_fwd_data_b,
   output logic [NUM_STAGES-1:0] o_stage_valid,
   output logic                  o_out_valid,
   output logic [DATA_W-1:0]     o_out_data,
   output logic [NB_ADDR-1:0]    o_out_rd,
   output logic                  o_out_regwrite
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]           o_bubble_cnt,
   output logic [31:0]           o_stall_cnt
`endif
);

   localparam int unsigned Last = NUM_STAGES - 1;

   logic [NUM_STAGES-1:0] valid_q, regwrite_q, hold;
   logic [DATA_W-1:0]     data_q [NUM_STAGES];
   logic [NB_ADDR-1:0]    rd_q   [NUM_STAGES];

   logic [NUM_STAGES-1:0] src_valid, src_regwrite;
   logic [DATA_W-1:0]     src_data [NUM_STAGES];
   logic [NB_ADDR-1:0]    src_rd   [NUM_STAGES];

   // A stall in any older stage freezes every younger stage behind it.
   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_hold
      assign hold[k] = |i_stall[Last:k];
   end

   // Stage k receives a bubble when stage k-1 is held but stage k is not.
   assign src_valid    = {valid_q[Last-1:0] & ~hold[Last-1:0], i_in_valid};
   assign src_regwrite = {regwrite_q[Last-1:0], i_in_regwrite};
   assign src_data[0]  = i_in_data;
   assign src_rd[0]    = i_in_rd;
   for (genvar k = 1; k < NUM_STAGES; k++) begin : g_src
      assign src_data[k] = data_q[k-1];
      assign src_rd[k]   = rd_q[k-1];
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         valid_q    <= '0;
         regwrite_q <= '0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            data_q[k] <= '0;
            rd_q[k]   <= '0;
         end
      end else if (i_dunit_clk_en) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (i_flush[k]) begin
               valid_q[k] <= 1'b0;
            end else if (!hold[k]) begin
               valid_q[k]    <= src_valid[k];
               regwrite_q[k] <= src_regwrite[k];
               data_q[k]     <= src_data[k];
               rd_q[k]       <= src_rd[k];
            end
         end
      end
   end

   // Gated by reset so every output reads 0 while reset is held.
   assign o_in_ready     = i_reset & i_dunit_clk_en & ~hold[0];
   assign o_stage_valid  = valid_q;
   assign o_out_valid    = valid_q[Last];
   assign o_out_data     = data_q[Last];
   assign o_out_rd       = rd_q[Last];
   assign o_out_regwrite = valid_q[Last] & regwrite_q[Last];

   // Scan oldest to youngest so the youngest hit overwrites older ones.
   always_comb begin
      o_fwd_a      = '0;
      o_fwd_b      = '0;
      o_fwd_data_a = '0;
      o_fwd_data_b = '0;
      for (int k = Last; k >= 0; k--) begin
         if (valid_q[k] && regwrite_q[k] && (rd_q[k] == i_rs_addr) && (|i_rs_addr)) begin
            o_fwd_a      = NB_SEL'(k + 1);
            o_fwd_data_a = data_q[k];
         end
         if (valid_q[k] && regwrite_q[k] && (rd_q[k] == i_rt_addr) && (|i_rt_addr)) begin
            o_fwd_b      = NB_SEL'(k + 1);
            o_fwd_data_b = data_q[k];
         end
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] bubble_cnt_q, stall_cnt_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else if (i_dunit_clk_en) begin
         if (!valid_q[Last] && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
         if (hold[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign o_bubble_cnt = bubble_cnt_q;
   assign o_stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (NUM_STAGES=4).
// Counter checks are compiled in when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_chain;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned NB_ADDR    = 5;
   localparam int unsigned NUM_STAGES = 4;
   localparam int unsigned NB_SEL     = $clog2(NUM_STAGES + 1);

   logic                  i_clk = 1'b0;
   logic                  i_reset;
   logic                  i_dunit_clk_en;
   logic                  i_in_valid;
   logic [DATA_W-1:0]     i_in_data;
   logic [NB_ADDR-1:0]    i_in_rd;
   logic                  i_in_regwrite;
   logic                  o_in_ready;
   logic [NUM_STAGES-1:0] i_stall;
   logic [NUM_STAGES-1:0] i_flush;
   logic [NB_ADDR-1:0]    i_rs_addr;
   logic [NB_ADDR-1:0]    i_rt_addr;
   logic [NB_SEL-1:0]     o_fwd_a;
   logic [NB_SEL-1:0]     o_fwd_b;
   logic [DATA_W-1:0]     o_fwd_data_a;
   logic [DATA_W-1:0]     o_fwd_data_b;
   logic [NUM_STAGES-1:0] o_stage_valid;
   logic                  o_out_valid;
   logic [DATA_W-1:0]     o_out_data;
   logic [NB_ADDR-1:0]    o_out_rd;
   logic                  o_out_regwrite;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0]           o_bubble_cnt;
   logic [31:0]           o_stall_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   pipe_stage_chain #(
      .DATA_W     (DATA_W),
      .NB_ADDR    (NB_ADDR),
      .NUM_STAGES (NUM_STAGES)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_dunit_clk_en (i_dunit_clk_en),
      .i_in_valid     (i_in_valid),
      .i_in_data      (i_in_data),
      .i_in_rd        (i_in_rd),
      .i_in_regwrite  (i_in_regwrite),
      .o_in_ready     (o_in_ready),
      .i_stall        (i_stall),
      .i_flush        (i_flush),
      .i_rs_addr      (i_rs_addr),
      .i_rt_addr      (i_rt_addr),
      .o_fwd_a        (o_fwd_a),
      .o_fwd_b        (o_fwd_b),
      .o_fwd_data_a   (o_fwd_data_a),
      .o_fwd_data_b   (o_fwd_data_b),
      .o_stage_valid  (o_stage_valid),
      .o_out_valid    (o_out_valid),
      .o_out_data     (o_out_data),
      .o_out_rd       (o_out_rd),
      .o_out_regwrite (o_out_regwrite)
`ifdef PIPE_PERF_CNT_EN
      ,
      .o_bubble_cnt   (o_bubble_cnt),
      .o_stall_cnt    (o_stall_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [NB_ADDR-1:0] rd);
      i_in_valid    = v;
      i_in_data     = d;
      i_in_rd       = rd;
      i_in_regwrite = 1'b1;
   endtask

   initial begin
      i_reset        = 1'b0;
      i_dunit_clk_en = 1'b1;
      i_stall        = '0;
      i_flush        = '0;
      i_rs_addr      = '0;
      i_rt_addr      = '0;
      drive(1'b0, '0, '0);

      // Reset state
      #3;
      check("rst_stage_valid", o_stage_valid, 4'b0000);
      check("rst_out_valid", o_out_valid, 1'b0);
      check("rst_out_data", o_out_data, 32'h0);
      check("rst_in_ready", o_in_ready, 1'b0);
      i_reset = 1'b1;

      // T1 flow
      drive(1'b1, 32'h11, 5'd1);
      step();
      drive(1'b1, 32'h22, 5'd2);
      step();
      drive(1'b1, 32'h33, 5'd3);
      step();
      check("t1_out_valid_early", o_out_valid, 1'b0);
      drive(1'b1, 32'h44, 5'd4);
      step();
      check("t1_out_valid", o_out_valid, 1'b1);
      check("t1_out_data", o_out_data, 32'h11);
      check("t1_out_rd", o_out_rd, 5'd1);
      check("t1_out_regwrite", o_out_regwrite, 1'b1);
      check("t1_stage_valid", o_stage_valid, 4'b1111);

      // Forwarding on the full chain: rd 4,3,2,1 in stages 0..3
      i_rs_addr = 5'd2;
      i_rt_addr = 5'd1;
      #1;
      check("full_fwd_a", o_fwd_a, 3'd3);
      check("full_fwd_data_a", o_fwd_data_a, 32'h22);
      check("full_fwd_b", o_fwd_b, 3'd4);
      check("full_fwd_data_b", o_fwd_data_b, 32'h11);

      // T2 stall on stage 1
      drive(1'b1, 32'h55, 5'd5);
      i_stall = 4'b0010;
      #1;
      check("t2_in_ready_stall", o_in_ready, 1'b0);
      step();
      check("t2_stage_valid", o_stage_valid, 4'b1011);
      check("t2_out_data", o_out_data, 32'h22);
      i_stall = 4'b0000;
      #1;
      check("t2_in_ready_free", o_in_ready, 1'b1);
      step();
      check("t2_stage_valid_after", o_stage_valid, 4'b0111);
      check("t2_out_valid_bubble", o_out_valid, 1'b0);

      // T3 forwarding priority
      drive(1'b1, 32'hBB, 5'd5);
      step();
      drive(1'b1, 32'hCC, 5'd7);
      step();
      drive(1'b1, 32'hAA, 5'd5);
      step();
      i_rs_addr = 5'd5;
      i_rt_addr = 5'd7;
      #1;
      check("t3_fwd_a", o_fwd_a, 3'd1);
      check("t3_fwd_data_a", o_fwd_data_a, 32'hAA);
      check("t3_fwd_b", o_fwd_b, 3'd2);
      check("t3_fwd_data_b", o_fwd_data_b, 32'hCC);
      i_rs_addr = 5'd0;
      #1;
      check("t3_fwd_a_zero", o_fwd_a, 3'd0);
      check("t3_fwd_data_a_zero", o_fwd_data_a, 32'h0);

      // T4 flush beats stall on stage 1
      drive(1'b1, 32'hDD, 5'd6);
      i_flush   = 4'b0010;
      i_stall   = 4'b0010;
      step();
      i_flush   = '0;
      i_stall   = '0;
      i_rs_addr = 5'd5;
      i_rt_addr = 5'd6;
      #1;
      check("t4_stage_valid", o_stage_valid, 4'b1001);
      check("t4_stage0_kept_fwd", o_fwd_a, 3'd1);
      check("t4_stage0_kept_data", o_fwd_data_a, 32'hAA);
      check("t4_no_dd_fwd", o_fwd_b, 3'd0);
      check("t4_out_data", o_out_data, 32'hBB);

      // T6a disabled clock enable freezes everything
      i_dunit_clk_en = 1'b0;
      drive(1'b1, 32'hEE, 5'd8);
      #1;
      check("t6_in_ready_dis", o_in_ready, 1'b0);
      step();
      step();
      step();
      check("t6_frozen_valid", o_stage_valid, 4'b1001);
      check("t6_frozen_out", o_out_data, 32'hBB);
      check("t6_frozen_fwd", o_fwd_data_a, 32'hAA);

      // T5 reset mid-run on a full chain
      i_dunit_clk_en = 1'b1;
      step();
      step();
      step();
      step();
      i_rs_addr = 5'd8;
      #1;
      check("t5_full_before", o_stage_valid, 4'b1111);
      check("t5_fwd_before", o_fwd_a, 3'd1);
      #1;
      i_reset = 1'b0;
      #1;
      check("t5_rst_stage_valid", o_stage_valid, 4'b0000);
      check("t5_rst_out_valid", o_out_valid, 1'b0);
      check("t5_rst_out_data", o_out_data, 32'h0);
      check("t5_rst_out_rd", o_out_rd, 5'd0);
      check("t5_rst_fwd", o_fwd_a, 3'd0);

      // T6b counters from a clean reset
      i_dunit_clk_en = 1'b0;
      drive(1'b0, '0, '0);
      #1;
      i_reset = 1'b1;
      step();
      step();
      step();
      check("t6_empty_valid", o_stage_valid, 4'b0000);
`ifdef PIPE_PERF_CNT_EN
      check("t6_bubble_dis", o_bubble_cnt, 32'd0);
`endif
      i_dunit_clk_en = 1'b1;
      step();
      step();
      step();
`ifdef PIPE_PERF_CNT_EN
      check("t6_bubble_cnt", o_bubble_cnt, 32'd3);
      check("t6_stall_cnt0", o_stall_cnt, 32'd0);
      i_stall = 4'b0001;
      step();
      i_stall = '0;
      check("t6_stall_cnt1", o_stall_cnt, 32'd1);
      check("t6_bubble_cnt4", o_bubble_cnt, 32'd4);
`endif
      check("t6_end_out_valid", o_out_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
